// File: rtl/execute_stage_if.sv
// Purpose: ID/EX input stream and EX/MEM output stream of the execute stage.
// Latency: none; plain signal bundle.
// Backpressure: in_ready towards decode, out_ready from the memory stage.
// Ports: in_bundle/in_valid/in_ready (decode side), out_bundle/out_valid/out_ready (memory side).
// Modports: slave = execute stage, master = surrounding pipeline or bench.
interface execute_stage_if #(
    parameter int WIDTH = 24,
    parameter int PC_W  = 32,
    parameter int IN_W  = PC_W + 2 + 4 + 5 + 4 + 3 * (4 + WIDTH) + WIDTH,
    parameter int OUT_W = PC_W + 3 + 4 + 2 * WIDTH
);
    logic [IN_W-1:0]  in_bundle;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_bundle;
    logic             out_valid;
    logic             out_ready;

    modport slave (
        input  in_bundle, in_valid, out_ready,
        output in_ready, out_bundle, out_valid
    );

    modport master (
        output in_bundle, in_valid, out_ready,
        input  in_ready, out_bundle, out_valid
    );
endinterface

// File: rtl/execute_stage.sv
// Purpose: execute stage - operand select, 24-bit ALU, shift-add multiply, branch resolve.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for multiply (aluControl 7).
// Backpressure: in_ready low while multiplying or while a result is held with out_ready low.
// Ports: clk, rst (async active-low), bus (execute_stage_if.slave: ID/EX in, EX/MEM out),
//        flush (sync kill), WE/Rd/WD (writeback forwarding source), branchTaken/branchTarget
//        (registered branch resolution), busy (multiply in progress).
// Build option: define FORWARD_EN to forward writeback data into Ra/Rb/Rc operands at accept.
module execute_stage #(
    parameter int WIDTH = 24,
    parameter int PC_W  = 32,
    parameter int IN_W  = PC_W + 2 + 4 + 5 + 4 + 3 * (4 + WIDTH) + WIDTH,
    parameter int OUT_W = PC_W + 3 + 4 + 2 * WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    execute_stage_if.slave    bus,
    input  logic              flush,
    input  logic              WE,
    input  logic [3:0]        Rd,
    input  logic [WIDTH-1:0]  WD,
    output logic              branchTaken,
    output logic [PC_W-1:0]   branchTarget,
    output logic              busy
);
    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [1:0]       op_type;
        logic [3:0]       op_code;
        logic             imm_src;
        logic             branch_flag;
        logic             mem_write;
        logic             mem_to_reg;
        logic             reg_write;
        logic [3:0]       alu_ctl;
        logic [3:0]       ra;
        logic [WIDTH-1:0] rd1;
        logic [3:0]       rb;
        logic [WIDTH-1:0] rd2;
        logic [3:0]       rc;
        logic [WIDTH-1:0] rd3;
        logic [WIDTH-1:0] ext_imm;
    } id_ex_t;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             mem_write;
        logic             mem_to_reg;
        logic             reg_write;
        logic [3:0]       rc;
        logic [WIDTH-1:0] alu_result;
        logic [WIDTH-1:0] store_data;
    } ex_mem_t;

    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [3:0] ALU_MUL  = 4'd7;
    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);

    state_t           state_q;
    ex_mem_t          out_q;
    logic             out_vld_q;
    logic             br_taken_q;
    logic [PC_W-1:0]  br_target_q;
    logic             busy_q;
    logic [4:0]       cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    ex_mem_t          mul_meta_q;
    logic             mul_bf_q;
    logic [PC_W-1:0]  mul_tgt_q;

    id_ex_t           ib;
    logic             slot_free;
    logic             accept;
    logic [WIDTH-1:0] opa, opb, sd;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] prod_d;
    logic [PC_W-1:0]  cur_tgt;
    ex_mem_t          cur_meta;
    ex_mem_t          pub;
    logic             pub_bf;
    logic [PC_W-1:0]  pub_tgt;
    logic             pub_vld;
    logic             pub_taken;
    logic             mul_done;
    logic             unused_ok;

    assign ib        = bus.in_bundle;
    assign slot_free = ~out_vld_q | bus.out_ready;
    assign bus.in_ready = (state_q == IDLE) & slot_free & ~flush;
    assign accept    = bus.in_valid & bus.in_ready;

`ifdef FORWARD_EN
    function automatic logic [WIDTH-1:0] fwd(input logic [3:0] r, input logic [WIDTH-1:0] v,
                                             input logic we, input logic [3:0] rd,
                                             input logic [WIDTH-1:0] wd);
        // r0 is hard-wired, so a writeback to it never overrides the bundle value
        return (we && rd != 4'd0 && r == rd) ? wd : v;
    endfunction

    assign opa = fwd(ib.ra, ib.rd1, WE, Rd, WD);
    assign opb = ib.imm_src ? ib.ext_imm : fwd(ib.rb, ib.rd2, WE, Rd, WD);
    assign sd  = fwd(ib.rc, ib.rd3, WE, Rd, WD);
    assign unused_ok = ^{ib.op_type, ib.op_code};
`else
    assign opa = ib.rd1;
    assign opb = ib.imm_src ? ib.ext_imm : ib.rd2;
    assign sd  = ib.rd3;
    assign unused_ok = ^{ib.op_type, ib.op_code, ib.ra, ib.rb, WE, Rd, WD};
`endif

    function automatic logic [WIDTH-1:0] alu(input logic [3:0] ctl,
                                             input logic [WIDTH-1:0] a, b);
        logic big;
        big = (b[4:0] >= 5'(WIDTH));
        case (ctl)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return big ? '0 : a << b[4:0];
            4'd6:    return big ? '0 : a >> b[4:0];
            4'd8:    return b;
            default: return '0;  // 7 goes through the multiplier; 9-15 are reserved
        endcase
    endfunction

    assign alu_res = alu(ib.alu_ctl, opa, opb);
    assign cur_tgt = ib.pc + {{(PC_W - WIDTH){ib.ext_imm[WIDTH-1]}}, ib.ext_imm};

    // Branches never write the register file or memory, regardless of the decoded controls.
    assign cur_meta = '{pc:         ib.pc,
                        mem_write:  ib.mem_write & ~ib.branch_flag,
                        mem_to_reg: ib.mem_to_reg,
                        reg_write:  ib.reg_write & ~ib.branch_flag,
                        rc:         ib.rc,
                        alu_result: alu_res,
                        store_data: sd};

    // Shift-add: multiplicand walks left, multiplier walks right, one bit per cycle.
    assign prod_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    // Product only leaves when the output register can take it; otherwise it waits here.
    assign mul_done = (state_q == MUL) & (cnt_q == LAST_BIT) & slot_free;
    assign pub_vld  = (accept & (ib.alu_ctl != ALU_MUL)) | mul_done;

    always_comb begin
        pub            = mul_meta_q;
        pub.alu_result = prod_d;
        pub_bf         = mul_bf_q;
        pub_tgt        = mul_tgt_q;
        if (state_q == IDLE) begin
            pub     = cur_meta;
            pub_bf  = ib.branch_flag;
            pub_tgt = cur_tgt;
        end
    end

    assign pub_taken = pub_vld & pub_bf & (pub.alu_result == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mul_meta_q  <= '0;
            mul_bf_q    <= 1'b0;
            mul_tgt_q   <= '0;
        end else if (flush) begin
            state_q    <= IDLE;
            out_vld_q  <= 1'b0;
            br_taken_q <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            br_taken_q <= pub_taken;
            if (pub_taken) begin
                br_target_q <= pub_tgt;
            end
            if (pub_vld) begin
                out_q     <= pub;
                out_vld_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_vld_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (accept && ib.alu_ctl == ALU_MUL) begin
                        state_q    <= MUL;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        acc_q      <= '0;
                        mcand_q    <= opa;
                        mplier_q   <= opb;
                        mul_meta_q <= cur_meta;
                        mul_bf_q   <= ib.branch_flag;
                        mul_tgt_q  <= cur_tgt;
                    end
                end
                MUL: begin
                    if (cnt_q != LAST_BIT) begin
                        acc_q    <= prod_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + 5'd1;
                    end else if (slot_free) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_bundle = out_q;
    assign bus.out_valid  = out_vld_q;
    assign branchTaken    = br_taken_q;
    assign branchTarget   = br_target_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_execute_stage.sv
`timescale 1ns/1ps
module tb_execute_stage;
    localparam int W    = 24;
    localparam int PCW  = 32;
    localparam int INW  = 155;
    localparam int OUTW = 87;
    localparam int NRND = 150;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic [1:0]     op_type;
        logic [3:0]     op_code;
        logic           imm_src;
        logic           branch_flag;
        logic           mem_write;
        logic           mem_to_reg;
        logic           reg_write;
        logic [3:0]     alu_ctl;
        logic [3:0]     ra;
        logic [W-1:0]   rd1;
        logic [3:0]     rb;
        logic [W-1:0]   rd2;
        logic [3:0]     rc;
        logic [W-1:0]   rd3;
        logic [W-1:0]   ext_imm;
    } instr_t;

    typedef struct packed {
        logic [PCW-1:0] pc;
        logic           mem_write;
        logic           mem_to_reg;
        logic           reg_write;
        logic [3:0]     rc;
        logic [W-1:0]   alu_result;
        logic [W-1:0]   store_data;
    } res_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           flush = 1'b0;
    logic           WE = 1'b0;
    logic [3:0]     Rd = 4'd0;
    logic [W-1:0]   WD = '0;
    logic           branchTaken;
    logic [PCW-1:0] branchTarget;
    logic           busy;
    int             checks = 0;
    int             errors = 0;

    execute_stage_if #(.WIDTH(W), .PC_W(PCW), .IN_W(INW), .OUT_W(OUTW)) bus ();

    execute_stage #(.WIDTH(W), .PC_W(PCW), .IN_W(INW), .OUT_W(OUTW)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .flush        (flush),
        .WE           (WE),
        .Rd           (Rd),
        .WD           (WD),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference ALU from the operation table, using plain integer arithmetic.
    function automatic logic [W-1:0] ref_alu(input int ctl, input longint a, input longint b);
        longint r;
        longint m;
        int     sh;
        m  = longint'(1) << W;
        sh = int'(b % 32);
        case (ctl)
            0:       r = (a + b) % m;
            1:       r = (a - b + m) % m;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = (sh >= W) ? 0 : (a * (longint'(1) << sh)) % m;
            6:       r = (sh >= W) ? 0 : a / (longint'(1) << sh);
            7:       r = (a * b) % m;
            8:       r = b;
            default: r = 0;
        endcase
        return r[W-1:0];
    endfunction

    // Expected EX/MEM bundle for an instruction accepted with the current WE/Rd/WD.
    function automatic res_t ref_out(input instr_t i);
        longint a, b, s;
        res_t   o;
        a = i.rd1;
        b = i.imm_src ? i.ext_imm : i.rd2;
        s = i.rd3;
`ifdef FORWARD_EN
        if (WE && Rd != 4'd0) begin
            if (i.ra == Rd) a = WD;
            if (!i.imm_src && i.rb == Rd) b = WD;
            if (i.rc == Rd) s = WD;
        end
`endif
        o.pc         = i.pc;
        o.mem_write  = i.mem_write && !i.branch_flag;
        o.mem_to_reg = i.mem_to_reg;
        o.reg_write  = i.reg_write && !i.branch_flag;
        o.rc         = i.rc;
        o.alu_result = ref_alu(int'(i.alu_ctl), a, b);
        o.store_data = s[W-1:0];
        return o;
    endfunction

    function automatic instr_t mk(input logic [3:0] ctl, input logic [W-1:0] a, input logic [W-1:0] b);
        instr_t i = '0;
        i.alu_ctl   = ctl;
        i.rd1       = a;
        i.rd2       = b;
        i.reg_write = 1'b1;
        i.rc        = 4'd2;
        i.rd3       = 24'h00C0DE;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.pc          = $urandom;
        i.op_type     = 2'($urandom);
        i.op_code     = 4'($urandom);
        i.imm_src     = 1'($urandom);
        i.branch_flag = ($urandom_range(0, 3) == 0);
        i.mem_write   = 1'($urandom);
        i.mem_to_reg  = 1'($urandom);
        i.reg_write   = 1'($urandom);
        i.alu_ctl     = 4'($urandom_range(0, 15));
        i.ra          = 4'($urandom);
        i.rd1         = W'($urandom);
        i.rb          = 4'($urandom);
        i.rd2         = W'($urandom);
        i.rc          = 4'($urandom);
        i.rd3         = W'($urandom);
        i.ext_imm     = W'($urandom);
        if ((i.alu_ctl == 4'd5 || i.alu_ctl == 4'd6) && $urandom_range(0, 1) == 1) begin
            i.rd2     = W'($urandom_range(0, 31));
            i.ext_imm = W'($urandom_range(0, 31));
        end
        if ($urandom_range(0, 7) == 0) i.rd2 = i.rd1;
        return i;
    endfunction

    // Present an instruction from a negedge, return at the negedge after it was accepted.
    task automatic send(input instr_t i, input string tag);
        bit ok = 1'b0;
        bus.in_bundle = i;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            #1;
            if (bus.in_ready) ok = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check({tag, "_accepted"}, ok, 1);
    endtask

    initial begin
        instr_t       i, j, cur;
        res_t         o, exp1;
        res_t         exp_q[$];
        logic [W-1:0] exp_fwd;
        int           nbusy, early, stable, seen, sent, cyc;
        bit           hold;

        bus.in_bundle = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_bundle", bus.out_bundle, 0);
        check("rst_busy", busy, 0);
        check("rst_branch_taken", branchTaken, 0);
        check("rst_branch_target", branchTarget, 0);
        check("rst_in_ready", bus.in_ready, 1);
        rst = 1'b1;
        @(negedge clk);

        // Immediate operand with wrap-around
        i = mk(4'd0, 24'hFFFFFF, 24'h0);
        i.imm_src = 1'b1;
        i.ext_imm = 24'h000002;
        send(i, "wrap");
        o = bus.out_bundle;
        check("wrap_valid", bus.out_valid, 1);
        check("wrap_result", o.alu_result, 24'h000001);
        check("wrap_bundle", bus.out_bundle, ref_out(i));
        @(negedge clk);
        check("wrap_valid_drop", bus.out_valid, 0);

        // Multiply: busy for WIDTH cycles, result after WIDTH cycles
        i = mk(4'd7, 24'h000123, 24'h000456);
        send(i, "mul");
        nbusy = 0;
        early = 0;
        for (int k = 0; k < 24; k++) begin
            if (busy && !bus.in_ready) nbusy++;
            if (bus.out_valid) early++;
            @(negedge clk);
        end
        o = bus.out_bundle;
        check("mul_busy_cycles", nbusy, 24);
        check("mul_no_early_valid", early, 0);
        check("mul_valid", bus.out_valid, 1);
        check("mul_result", o.alu_result, 24'h04EDC2);
        check("mul_busy_drop", busy, 0);

        // Backpressure: first result holds, second follows once out_ready rises
        @(negedge clk);
        bus.out_ready = 1'b0;
        i = mk(4'd0, 24'd1, 24'd2);
        exp1 = ref_out(i);
        send(i, "bp1");
        j = mk(4'd0, 24'd10, 24'd20);
        j.rc = 4'd5;
        bus.in_bundle = j;
        bus.in_valid  = 1'b1;
        stable = 0;
        repeat (3) begin
            #1;
            if (!bus.in_ready && bus.out_valid && bus.out_bundle == exp1) stable++;
            @(negedge clk);
        end
        check("bp_hold_cycles", stable, 3);
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready_back", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_second_valid", bus.out_valid, 1);
        check("bp_second_bundle", bus.out_bundle, ref_out(j));
        @(negedge clk);
        check("bp_drained", bus.out_valid, 0);

        // Branch taken and not taken
        i = mk(4'd1, 24'd9, 24'd9);
        i.branch_flag = 1'b1;
        i.mem_write   = 1'b1;
        i.pc          = 32'h100;
        i.ext_imm     = 24'hFFFFF0;
        send(i, "br");
        o = bus.out_bundle;
        check("br_taken", branchTaken, 1);
        check("br_target", branchTarget, 32'h0F0);
        check("br_regwrite", o.reg_write, 0);
        check("br_memwrite", o.mem_write, 0);
        check("br_valid", bus.out_valid, 1);
        @(negedge clk);
        check("br_pulse_end", branchTaken, 0);
        i.rd2 = 24'd8;
        send(i, "brn");
        check("brn_not_taken", branchTaken, 0);
        check("brn_bundle", bus.out_bundle, ref_out(i));

        // Forwarding from writeback
        i = mk(4'd0, 24'd1, 24'd4);
        i.ra = 4'd3;
        i.rb = 4'd5;
        WE = 1'b1;
        Rd = 4'd3;
        WD = 24'd50;
`ifdef FORWARD_EN
        exp_fwd = 24'd54;
`else
        exp_fwd = 24'd5;
`endif
        send(i, "fwd");
        o = bus.out_bundle;
        check("fwd_result", o.alu_result, exp_fwd);
        i.ra = 4'd0;
        Rd   = 4'd0;
        send(i, "fwd_r0");
        o = bus.out_bundle;
        check("fwd_r0_result", o.alu_result, 24'd5);
        WE = 1'b0;

        // Shift boundaries
        send(mk(4'd5, 24'h000ABC, 24'd24), "shl24");
        o = bus.out_bundle;
        check("shl24_result", o.alu_result, 24'h0);
        send(mk(4'd5, 24'h000ABC, 24'd4), "shl4");
        o = bus.out_bundle;
        check("shl4_result", o.alu_result, 24'h00ABC0);
        send(mk(4'd6, 24'h800000, 24'd23), "shr23");
        o = bus.out_bundle;
        check("shr23_result", o.alu_result, 24'h000001);

        // Flush during multiply
        send(mk(4'd7, 24'd3, 24'd5), "flmul");
        repeat (5) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_in_ready", bus.in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        check("flmul_busy", busy, 0);
        check("flmul_valid", bus.out_valid, 0);
        seen = 0;
        repeat (30) begin
            if (bus.out_valid || busy) seen++;
            @(negedge clk);
        end
        check("flmul_aborted", seen, 0);

        // Flush during output hold, with a branch offered in the flush cycle
        bus.out_ready = 1'b0;
        send(mk(4'd0, 24'd1, 24'd1), "flhold");
        @(negedge clk);
        check("flhold_valid", bus.out_valid, 1);
        i = mk(4'd1, 24'd7, 24'd7);
        i.branch_flag = 1'b1;
        bus.in_bundle = i;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        flush = 1'b1;
        #1;
        check("flhold_no_accept", bus.in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flhold_valid_drop", bus.out_valid, 0);
        check("flhold_no_branch", branchTaken, 0);

        // Reset in the middle of a multiply
        send(mk(4'd7, 24'h000123, 24'h000456), "rstmul");
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmul_busy", busy, 0);
        check("rstmul_valid", bus.out_valid, 0);
        check("rstmul_bundle", bus.out_bundle, 0);
        check("rstmul_target", branchTarget, 0);
        check("rstmul_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(mk(4'd0, 24'd5, 24'd7), "post_rst_add");
        o = bus.out_bundle;
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_result", o.alu_result, 24'd12);
        @(negedge clk);

        // Randomized traffic against the reference model
        sent = 0;
        cyc  = 0;
        hold = 1'b0;
        cur  = '0;
        while ((sent < NRND || exp_q.size() != 0) && cyc < 20000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            WE = 1'($urandom);
            Rd = 4'($urandom_range(0, 15));
            WD = W'($urandom);
            if (!hold) begin
                if (sent < NRND && $urandom_range(0, 2) != 0) begin
                    cur = rand_instr();
                    bus.in_bundle = cur;
                    bus.in_valid  = 1'b1;
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            #1;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("rnd_unexpected_out", bus.out_valid, 0);
                else                   check("rnd_out", bus.out_bundle, exp_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_out(cur));
                sent++;
                hold = 1'b0;
            end else begin
                hold = bus.in_valid;
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("rnd_sent", sent, NRND);
        check("rnd_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
